// File: rtl/time_keeper.sv
// time_keeper: 24-hour BCD wall clock plus alarm, advanced by the one-minute pulse stream.
// Every control input is synchronised and edge-detected in the clk5MHz domain.

module time_keeper #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned RING_MINUTES = 5
) (
  input  logic       clk5MHz,
  input  logic       reset,
  input  logic       pulse1min,
  input  logic       hourAdv,
  input  logic       alarmMinAdv,
  input  logic       setAlarm,
  input  logic       alarmEnable,
  input  logic       alarmOff,
  output logic [7:0] hoursBCD,
  output logic [7:0] minutesBCD,
  output logic [7:0] alarmHoursBCD,
  output logic [7:0] alarmMinutesBCD,
  output logic       minuteTick,
  output logic       alarmRing
);

  localparam int unsigned NumIn     = 6;
  localparam int unsigned NumEdge   = 4;
  localparam logic [5:0]  RingLimit = 6'(RING_MINUTES);

  typedef enum logic [0:0] {StIdle, StRinging} ring_state_e;

  function automatic logic [7:0] hour_inc(input logic [7:0] h);
    logic [7:0] r;
    if (h == 8'h23) begin
      r = 8'h00;
    end else if (h[3:0] == 4'd9) begin
      r = {h[7:4] + 4'd1, 4'd0};
    end else begin
      r = {h[7:4], h[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] min_inc(input logic [7:0] m);
    logic [7:0] r;
    if (m[3:0] != 4'd9) begin
      r = {m[7:4], m[3:0] + 4'd1};
    end else if (m[7:4] == 4'd5) begin
      r = 8'h00;
    end else begin
      r = {m[7:4] + 4'd1, 4'd0};
    end
    return r;
  endfunction

  // Input synchronisers. Bits [3:0] are edge-counted, bits [5:4] are levels.
  logic [NumIn-1:0]                  async_in;
  logic [SYNC_STAGES-1:0][NumIn-1:0] sync_q;
  logic [NumIn-1:0]                  synced;
  logic [NumIn-1:0]                  level_q;
  logic [NumEdge-1:0]                edge_q;

  assign async_in = {alarmEnable, setAlarm, alarmOff, alarmMinAdv, hourAdv, pulse1min};
  assign synced   = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk5MHz) begin
    if (!reset) begin
      sync_q  <= '0;
      level_q <= '0;
      edge_q  <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      level_q <= synced;
      edge_q  <= synced[NumEdge-1:0] & ~level_q[NumEdge-1:0];
    end
  end

  // Levels are taken from level_q so they line up with the registered edge strobes.
  logic pulse_edge, hour_edge, amin_edge, off_edge, set_alarm, alarm_en;

  assign pulse_edge = edge_q[0];
  assign hour_edge  = edge_q[1];
  assign amin_edge  = edge_q[2];
  assign off_edge   = edge_q[3];
  assign set_alarm  = level_q[4];
  assign alarm_en   = level_q[5];

  logic [7:0] hour_q, hour_d;
  logic [7:0] min_q, min_d;
  logic [7:0] ahour_q, ahour_d;
  logic [7:0] amin_q, amin_d;
  logic       match_q, match_d;
  logic       hour_carry, time_hour_edit, time_upd;

  always_comb begin
    min_d          = min_q;
    hour_d         = hour_q;
    ahour_d        = ahour_q;
    amin_d         = amin_q;
    hour_carry     = pulse_edge & (min_q == 8'h59);
    time_hour_edit = hour_edge & ~set_alarm;
    time_upd       = pulse_edge | time_hour_edit;

    if (pulse_edge) begin
      min_d = min_inc(min_q);
    end
    // Carry and button can both land in one cycle: two hour steps.
    if (hour_carry) begin
      hour_d = hour_inc(hour_d);
    end
    if (time_hour_edit) begin
      hour_d = hour_inc(hour_d);
    end

    if (hour_edge && set_alarm) begin
      ahour_d = hour_inc(ahour_q);
    end
    if (amin_edge && set_alarm) begin
      amin_d = min_inc(amin_q);
    end

    // Only time updates may arm a ring; alarm edits alone never do.
    match_d = time_upd & ({hour_d, min_d} == {ahour_d, amin_d});
  end

  always_ff @(posedge clk5MHz) begin
    if (!reset) begin
      hour_q  <= 8'h00;
      min_q   <= 8'h00;
      ahour_q <= 8'h00;
      amin_q  <= 8'h00;
      match_q <= 1'b0;
    end else begin
      hour_q  <= hour_d;
      min_q   <= min_d;
      ahour_q <= ahour_d;
      amin_q  <= amin_d;
      match_q <= match_d;
    end
  end

  ring_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  cnt_inc;
  logic        trigger;

  assign cnt_inc = cnt_q + 6'd1;
  assign trigger = match_q & alarm_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StRinging;
          cnt_d   = 6'd0;
        end
      end
      StRinging: begin
        if (trigger) begin
          cnt_d = 6'd0;
        end else if (off_edge || !alarm_en) begin
          state_d = StIdle;
          cnt_d   = 6'd0;
        end else if (pulse_edge) begin
          if (cnt_inc == RingLimit) begin
            state_d = StIdle;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk5MHz) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hoursBCD        = hour_q;
  assign minutesBCD      = min_q;
  assign alarmHoursBCD   = ahour_q;
  assign alarmMinutesBCD = amin_q;
  assign minuteTick      = pulse_edge;
  assign alarmRing       = (state_q == StRinging);

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed scenarios plus randomized ops against a minutes-of-day model.
`timescale 1ns/1ps

module tb_time_keeper;

  localparam int unsigned RingMin = 5;

  logic clk5MHz = 1'b0;
  logic reset = 1'b0;
  logic pulse1min = 1'b0, hourAdv = 1'b0, alarmMinAdv = 1'b0;
  logic setAlarm = 1'b0, alarmEnable = 1'b0, alarmOff = 1'b0;
  logic [7:0] hoursBCD, minutesBCD, alarmHoursBCD, alarmMinutesBCD;
  logic minuteTick, alarmRing;

  int checks = 0;
  int errors = 0;
  int ticks_seen = 0;
  int ring_rises = 0;
  logic ring_prev = 1'b0;

  // Model: time as minutes of day, alarm as hour/minute integers.
  int m_t = 0, m_ah = 0, m_am = 0, m_left = 0;
  bit m_ring = 1'b0, m_en = 1'b0, m_set = 1'b0;

  logic [32:0] dut_vec;
  assign dut_vec = {hoursBCD, minutesBCD, alarmHoursBCD, alarmMinutesBCD, alarmRing};

  time_keeper #(
    .SYNC_STAGES (2),
    .RING_MINUTES(RingMin)
  ) dut (
    .clk5MHz        (clk5MHz),
    .reset          (reset),
    .pulse1min      (pulse1min),
    .hourAdv        (hourAdv),
    .alarmMinAdv    (alarmMinAdv),
    .setAlarm       (setAlarm),
    .alarmEnable    (alarmEnable),
    .alarmOff       (alarmOff),
    .hoursBCD       (hoursBCD),
    .minutesBCD     (minutesBCD),
    .alarmHoursBCD  (alarmHoursBCD),
    .alarmMinutesBCD(alarmMinutesBCD),
    .minuteTick     (minuteTick),
    .alarmRing      (alarmRing)
  );

  always #5 clk5MHz = ~clk5MHz;

  always @(negedge clk5MHz) begin
    if (minuteTick === 1'b1) ticks_seen <= ticks_seen + 1;
    if (alarmRing === 1'b1 && ring_prev !== 1'b1) ring_rises <= ring_rises + 1;
    ring_prev <= alarmRing;
  end

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [32:0] exp_vec();
    return {bcd(m_t / 60), bcd(m_t % 60), bcd(m_ah), bcd(m_am), m_ring};
  endfunction

  // mask: [0] pulse1min, [1] hourAdv, [2] alarmMinAdv, [3] alarmOff
  task automatic model_event(input logic [3:0] mask);
    bit time_upd;
    time_upd = 1'b0;
    if (mask[0]) begin
      m_t = (m_t + 1) % 1440;
      time_upd = 1'b1;
    end
    if (mask[1] && !m_set) begin
      m_t = (m_t + 60) % 1440;
      time_upd = 1'b1;
    end
    if (mask[1] && m_set) m_ah = (m_ah + 1) % 24;
    if (mask[2] && m_set) m_am = (m_am + 1) % 60;
    if (mask[3]) m_ring = 1'b0;
    if (mask[0] && m_ring) begin
      m_left = m_left - 1;
      if (m_left == 0) m_ring = 1'b0;
    end
    if (time_upd && m_en && m_t == m_ah * 60 + m_am) begin
      m_ring = 1'b1;
      m_left = RingMin;
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    m_ah = 0;
    m_am = 0;
    m_ring = 1'b0;
    m_left = 0;
  endtask

  task automatic press(input logic [3:0] mask, input int hi);
    @(negedge clk5MHz);
    if (mask[0]) pulse1min = 1'b1;
    if (mask[1]) hourAdv = 1'b1;
    if (mask[2]) alarmMinAdv = 1'b1;
    if (mask[3]) alarmOff = 1'b1;
    repeat (hi) @(negedge clk5MHz);
    pulse1min = 1'b0;
    hourAdv = 1'b0;
    alarmMinAdv = 1'b0;
    alarmOff = 1'b0;
    @(negedge clk5MHz);
  endtask

  task automatic step(input logic [3:0] mask);
    press(mask, int'($urandom_range(1, 3)));
    model_event(mask);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk5MHz);
  endtask

  task automatic set_level_alarm(input logic v);
    @(negedge clk5MHz);
    setAlarm = v;
    m_set = v;
    settle();
  endtask

  task automatic apply_reset();
    @(negedge clk5MHz);
    reset = 1'b0;
    @(negedge clk5MHz);
    reset = 1'b1;
    model_reset();
    settle();
  endtask

  task automatic test_reset();
    int t0;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk5MHz);
      {pulse1min, hourAdv, alarmMinAdv, setAlarm, alarmEnable, alarmOff} = 6'($urandom);
      @(posedge clk5MHz);
      #1;
      checks++;
      if ({dut_vec, minuteTick} !== 34'h0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got %h expected 0", i, {dut_vec, minuteTick});
      end
    end
    // Release with pulse1min already high: exactly one edge is expected.
    @(negedge clk5MHz);
    {hourAdv, alarmMinAdv, setAlarm, alarmEnable, alarmOff} = 5'b0;
    pulse1min = 1'b1;
    @(negedge clk5MHz);
    reset = 1'b1;
    model_reset();
    t0 = ticks_seen;
    settle();
    pulse1min = 1'b0;
    model_event(4'b0001);
    checks++;
    if ({hoursBCD, minutesBCD} !== 16'h0001 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_held_input: got %h expected %h", dut_vec, exp_vec());
    end
    repeat (58) step(4'b0001);
    settle();
    checks++;
    if ({hoursBCD, minutesBCD} !== 16'h0059 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL count_59: got %h expected %h", dut_vec, exp_vec());
    end
    step(4'b0001);
    settle();
    checks++;
    if ({hoursBCD, minutesBCD} !== 16'h0100 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL carry_0100: got %h expected %h", dut_vec, exp_vec());
    end
    checks++;
    if (ticks_seen - t0 !== 60) begin
      errors++;
      $display("FAIL tick_count: got %0d expected 60", ticks_seen - t0);
    end
  endtask

  task automatic test_wrap();
    int t0;
    repeat (22) step(4'b0010);
    repeat (59) step(4'b0001);
    settle();
    checks++;
    if ({hoursBCD, minutesBCD} !== 16'h2359 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reach_2359: got %h expected %h", dut_vec, exp_vec());
    end
    step(4'b0001);
    settle();
    checks++;
    if ({hoursBCD, minutesBCD} !== 16'h0000 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL wrap_0000: got %h expected %h", dut_vec, exp_vec());
    end
    t0 = ticks_seen;
    press(4'b0001, 1000);
    model_event(4'b0001);
    settle();
    checks++;
    if ({hoursBCD, minutesBCD} !== 16'h0001 || ticks_seen - t0 !== 1) begin
      errors++;
      $display("FAIL long_hold: got %h ticks %0d expected 0001 ticks 1",
               {hoursBCD, minutesBCD}, ticks_seen - t0);
    end
  endtask

  task automatic test_simultaneous();
    int t0;
    repeat (22) step(4'b0010);
    repeat (58) step(4'b0001);
    settle();
    t0 = ticks_seen;
    step(4'b0011);
    settle();
    checks++;
    if ({hoursBCD, minutesBCD} !== 16'h0000 || dut_vec !== exp_vec() || ticks_seen - t0 !== 1) begin
      errors++;
      $display("FAIL both_2259: got %h ticks %0d expected %h ticks 1",
               dut_vec, ticks_seen - t0, exp_vec());
    end
    repeat (9) step(4'b0010);
    repeat (15) step(4'b0001);
    settle();
    t0 = ticks_seen;
    step(4'b0010);
    settle();
    checks++;
    if ({hoursBCD, minutesBCD} !== 16'h1015 || dut_vec !== exp_vec() || ticks_seen - t0 !== 0) begin
      errors++;
      $display("FAIL hour_0915: got %h ticks %0d expected %h ticks 0",
               dut_vec, ticks_seen - t0, exp_vec());
    end
    repeat (9) step(4'b0010);
    settle();
    checks++;
    if ({hoursBCD, minutesBCD} !== 16'h1915 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL hour_1915: got %h expected %h", dut_vec, exp_vec());
    end
    step(4'b0010);
    settle();
    checks++;
    if ({hoursBCD, minutesBCD} !== 16'h2015 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL hour_2015: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_alarm_set();
    int h, a, p, r0;
    apply_reset();
    set_level_alarm(1'b1);
    h = 7;
    a = 30;
    p = 3;
    while (h + a + p > 0) begin
      int r;
      r = int'($urandom_range(0, h + a + p - 1));
      if (r < h) begin
        step(4'b0010);
        h--;
      end else if (r < h + a) begin
        step(4'b0100);
        a--;
      end else begin
        step(4'b0001);
        p--;
      end
    end
    settle();
    checks++;
    if (dut_vec !== {16'h0003, 16'h0730, 1'b0} || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL alarm_0730: got %h expected %h", dut_vec, exp_vec());
    end
    @(negedge clk5MHz);
    alarmEnable = 1'b1;
    m_en = 1'b1;
    settle();
    r0 = ring_rises;
    repeat (17) step(4'b0010);
    repeat (33) step(4'b0100);
    settle();
    checks++;
    if (dut_vec !== {16'h0003, 16'h0003, 1'b0} || ring_rises - r0 !== 0) begin
      errors++;
      $display("FAIL edit_no_ring: got %h rises %0d expected %h rises 0",
               dut_vec, ring_rises - r0, exp_vec());
    end
    repeat (7) step(4'b0010);
    repeat (27) step(4'b0100);
    set_level_alarm(1'b0);
  endtask

  task automatic test_ring();
    repeat (7) step(4'b0010);
    repeat (26) step(4'b0001);
    settle();
    checks++;
    if (dut_vec !== {16'h0729, 16'h0730, 1'b0}) begin
      errors++;
      $display("FAIL pre_ring: got %h expected %h", dut_vec, {16'h0729, 16'h0730, 1'b0});
    end
    @(negedge clk5MHz);
    pulse1min = 1'b1;
    repeat (3) @(posedge clk5MHz);
    #1;
    checks++;
    if ({minuteTick, minutesBCD} !== 9'h129) begin
      errors++;
      $display("FAIL tick_latency: got %h expected 129", {minuteTick, minutesBCD});
    end
    @(posedge clk5MHz);
    #1;
    checks++;
    if ({minutesBCD, alarmRing} !== 9'h060) begin
      errors++;
      $display("FAIL update_edge: got %h expected 060", {minutesBCD, alarmRing});
    end
    @(posedge clk5MHz);
    #1;
    checks++;
    if (alarmRing !== 1'b1) begin
      errors++;
      $display("FAIL ring_rise: got %b expected 1", alarmRing);
    end
    @(negedge clk5MHz);
    pulse1min = 1'b0;
    model_event(4'b0001);
    repeat (4) step(4'b0001);
    settle();
    checks++;
    if (alarmRing !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL ring_0734: got %h expected %h", dut_vec, exp_vec());
    end
    step(4'b0001);
    settle();
    checks++;
    if (dut_vec !== {16'h0735, 16'h0730, 1'b0} || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL timeout_0735: got %h expected %h", dut_vec, exp_vec());
    end
    repeat (23) step(4'b0010);
    repeat (55) step(4'b0001);
    settle();
    checks++;
    if (dut_vec !== {16'h0730, 16'h0730, 1'b1} || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL next_day_ring: got %h expected %h", dut_vec, exp_vec());
    end
    @(negedge clk5MHz);
    alarmOff = 1'b1;
    repeat (3) @(posedge clk5MHz);
    #1;
    checks++;
    if (alarmRing !== 1'b1) begin
      errors++;
      $display("FAIL off_early: got %b expected 1", alarmRing);
    end
    @(posedge clk5MHz);
    #1;
    checks++;
    if (alarmRing !== 1'b0) begin
      errors++;
      $display("FAIL off_latency: got %b expected 0", alarmRing);
    end
    @(negedge clk5MHz);
    alarmOff = 1'b0;
    model_event(4'b1000);
    settle();
  endtask

  task automatic test_reset_midring();
    int r0;
    set_level_alarm(1'b1);
    step(4'b0100);
    set_level_alarm(1'b0);
    step(4'b0001);
    settle();
    checks++;
    if (alarmRing !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL ring_0731: got %h expected %h", dut_vec, exp_vec());
    end
    @(negedge clk5MHz);
    reset = 1'b0;
    @(posedge clk5MHz);
    #1;
    checks++;
    if ({dut_vec, minuteTick} !== 34'h0) begin
      errors++;
      $display("FAIL reset_midring: got %h expected 0", {dut_vec, minuteTick});
    end
    @(negedge clk5MHz);
    reset = 1'b1;
    model_reset();
    settle();
    set_level_alarm(1'b1);
    repeat (2) step(4'b0100);
    set_level_alarm(1'b0);
    @(negedge clk5MHz);
    alarmEnable = 1'b0;
    m_en = 1'b0;
    settle();
    r0 = ring_rises;
    repeat (2) step(4'b0001);
    settle();
    checks++;
    if (dut_vec !== {16'h0002, 16'h0002, 1'b0} || ring_rises - r0 !== 0) begin
      errors++;
      $display("FAIL disabled_match: got %h rises %0d expected %h rises 0",
               dut_vec, ring_rises - r0, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 6; round++) begin
      int k, tgt, hn, mn;
      k = int'($urandom_range(1, 4));
      tgt = (m_t + k) % 1440;
      hn = ((tgt / 60) - m_ah + 24) % 24;
      mn = ((tgt % 60) - m_am + 60) % 60;
      @(negedge clk5MHz);
      alarmEnable = ($urandom_range(0, 3) != 0);
      m_en = alarmEnable;
      if (!m_en) m_ring = 1'b0;
      set_level_alarm(1'b1);
      repeat (hn) step(4'b0010);
      repeat (mn) step(4'b0100);
      set_level_alarm(1'b0);
      for (int op = 0; op < 12; op++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 4) step(4'b0001);
        else if (r == 5) step(4'b0010);
        else if (r == 6) step(4'b0011);
        else if (r == 7) step(4'b1000);
        else if (r == 9) step(4'b0100);
        else begin
          @(negedge clk5MHz);
          alarmEnable = ~alarmEnable;
          m_en = alarmEnable;
          if (!m_en) m_ring = 1'b0;
        end
        settle();
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL random r%0d op%0d kind %0d: got %h expected %h",
                   round, op, r, dut_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_simultaneous();
    test_alarm_set();
    test_ring();
    test_reset_midring();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
# time_keeper

Consumes the one-minute pulse stream from the pulse generator and keeps the alarm clock's wall time as 24-hour BCD hours:minutes. Also holds a user-set alarm time and drives the alarm ring output. It sits between the pulse generator and the display/buzzer logic, all in the clk5MHz domain. Every control input is treated as asynchronous and edge-counted, so a held level advances the count exactly once.

## Interface
- SYNC_STAGES, 2: synchronizer flops on every asynchronous input (minimum 2).
- RING_MINUTES, 5: minute ticks after which an unacknowledged alarm stops ringing (1..59).
- clk5MHz  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on clk5MHz rising edge.
- pulse1min  in  1  minute pulse from the pulse generator (async level); each rising edge = +1 minute of time.
- hourAdv  in  1  debounced hour-set button (async); each rising edge = +1 hour to time or alarm.
- alarmMinAdv  in  1  debounced alarm-minute button (async); each rising edge = +1 alarm minute while setAlarm=1, otherwise ignored.
- setAlarm  in  1  level (synchronized); 1 = hourAdv edits alarm, 0 = hourAdv edits time.
- alarmEnable  in  1  level (synchronized); 0 forbids and cancels ringing.
- alarmOff  in  1  button (async); a rising edge acknowledges/silences the alarm.
- hoursBCD  out  8  time hours, [7:4] tens 0..2, [3:0] units 0..9.
- minutesBCD  out  8  time minutes, [7:4] tens 0..5, [3:0] units 0..9.
- alarmHoursBCD  out  8  alarm hours, same encoding.
- alarmMinutesBCD  out  8  alarm minutes, same encoding.
- minuteTick  out  1  one-cycle strobe on each pulse1min-driven minute advance.
- alarmRing  out  1  alarm active.

## Operation
- Every async input passes through a SYNC_STAGES flop chain. Rising edges are detected against one further registered copy. An edge = synced 1 with previous 0.
- Time minutes: on a pulse1min edge, the units digit increments. Units 9→0 carries into tens. Tens 5 with units 9 → 00 with hourCarry=1.
- Time hours: hours_next = (hours + hourCarry + (hourAdv edge & ~setAlarm)) mod 24, held in BCD.
  - 23→00, 09→10, 19→20.
  - Both increments in one cycle: +2 mod 24 (e.g. 22:59 → 00:00, 23:59 → 01:00).
- hourAdv never touches minutes. minuteTick pulses only for pulse1min edges.
- Alarm edits apply only while setAlarm=1:
  - hourAdv edge: alarm hour +1 mod 24.
  - alarmMinAdv edge: alarm minute +1 mod 60, with no carry into the alarm hour.
  - Both in the same cycle apply independently.
- Alarm edits never stop time keeping. pulse1min always advances time.
- Ring trigger: set in the cycle after any time update whose new value equals the alarm registers, provided synced alarmEnable=1.
  - Edits to the alarm registers never trigger, even if they make alarm equal to time.
  - A trigger while already ringing restarts the timeout count.
- Ring clear, whichever comes first:
  - an alarmOff edge;
  - synced alarmEnable=0;
  - RING_MINUTES minuteTicks after the trigger.
- Ring states: IDLE → RINGING on trigger. RINGING → IDLE on clear. Clear and trigger in the same cycle: trigger wins, count restarts.
- Reset (reset=0 at a clock edge), including mid-ring or mid-edit:
  - time = 00:00, alarm = 00:00;
  - alarmRing=0, minuteTick=0, ring count=0;
  - all synchronizer and edge flops = 0.
- After reset, an input already held high produces one edge once its synced value is seen.

## Timing
- Input high or low pulses must each last ≥1 clk5MHz cycle to be counted.
- Input edge → register update: an input first sampled high at edge k updates state at edge k+SYNC_STAGES+1, which is 3 cycles with the default.
- minuteTick is asserted during the cycle whose closing edge updates minutesBCD.
- alarmRing rises 1 cycle after the matching time update.
- alarmRing falls at the same latency as any other register update from the alarmOff or alarmEnable input.
- Outputs are registered with no combinational path from inputs.

## Test plan
- Reset: hold reset=0 with all inputs toggling → all BCD outputs 0x00, alarmRing=0, minuteTick=0. Release, then 59 pulse1min pulses → minutesBCD=0x59, hoursBCD=0x00. One more pulse → 01:00.
- Wrap: reach 23:59, one pulse1min → 00:00. Hold pulse1min high 1000 cycles → exactly one advance (00:01).
- Simultaneous: at 22:59, pulse1min and hourAdv rise together → 00:00. At 09:15, hourAdv only → 10:15, with no minuteTick.
- Alarm set: setAlarm=1, 7 hourAdv + 30 alarmMinAdv edges, 3 pulse1min meanwhile → alarm 07:30 and time 00:03. Edit alarm to equal time → no ring.
- Ring: alarmEnable=1, time 07:29, pulse1min → 07:30, alarmRing=1 one cycle later. 5 more minutes → cleared at 07:35. Repeat next day, then alarmOff edge → cleared after 3 cycles.
- Reset mid-ring: while alarmRing=1, reset=0 for one edge → alarmRing=0, time and alarm 00:00. alarmEnable=0 at match → never rings.
